trafficlights_controller_param: RTL and testbench

Parametrised two-road traffic-light controller with a single clock domain. It derives a 1 Hz tick enable from `tclk` and sequences green, yellow and all-red clearance phases for two roads. It also provides pedestrian-request green shortening and a flashing-yellow mode. It drives the lamp outputs and the countdown value shown on the board's display logic.

---
 rtl/trafficlights_controller_param.sv | 147 ++++++++++++++
 tb/tb_trafficlights_controller_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/trafficlights_controller_param.sv
// Two-road traffic-light sequencer with 1 Hz prescaler, pedestrian green
// shortening and a flashing-yellow override.
module trafficlights_controller_param #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GREEN0   = 45,
  parameter int unsigned GREEN1   = 25,
  parameter int unsigned YELLOW   = 5,
  parameter int unsigned ALLRED   = 2,
  parameter int unsigned PED_MIN  = 10
) (
  input  logic             tclk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             flash,
  output logic [2:0]       tf0,
  output logic [2:0]       tf1,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       phase,
  output logic             ped_pend
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    G0    = 3'd0,
    Y0    = 3'd1,
    R0    = 3'd2,
    G1    = 3'd3,
    Y1    = 3'd4,
    R1    = 3'd5,
    FLASH = 3'd6
  } phase_e;

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] count_d;
  logic             ped_d;
  logic             blink_q, blink_d;
  logic [2:0]       tf0_d, tf1_d;
  logic [PRE_W-1:0] pre_q;
  logic             tick_c;

  // Duration loaded into count on entry to a phase
  function automatic logic [CNT_W-1:0] dur(input phase_e p);
    case (p)
      G0:      dur = CNT_W'(GREEN0);
      Y0:      dur = CNT_W'(YELLOW);
      R0:      dur = CNT_W'(ALLRED);
      G1:      dur = CNT_W'(GREEN1);
      Y1:      dur = CNT_W'(YELLOW);
      R1:      dur = CNT_W'(ALLRED);
      default: dur = '0;
    endcase
  endfunction

  // Normal phase rotation G0 -> Y0 -> R0 -> G1 -> Y1 -> R1 -> G0
  function automatic phase_e nxt(input phase_e p);
    case (p)
      G0:      nxt = Y0;
      Y0:      nxt = R0;
      R0:      nxt = G1;
      G1:      nxt = Y1;
      Y1:      nxt = R1;
      default: nxt = G0;
    endcase
  endfunction

  assign tick_c = (pre_q == PRE_MAX);
  assign phase  = state_q;

  // Prescaler producing a one-cycle tick every TICK_DIV clocks
  always_ff @(posedge tclk) begin
    if (!rst)        pre_q <= '0;
    else if (tick_c) pre_q <= '0;
    else             pre_q <= pre_q + PRE_W'(1);
  end

  // Next phase, count, pedestrian latch, blink and lamp decode
  always_comb begin
    state_d = state_q;
    count_d = count;
    ped_d   = ped_pend;
    blink_d = blink_q;
    tf0_d   = 3'b100;
    tf1_d   = 3'b100;

    if (tick_c) begin
      if (state_q != FLASH && flash) begin
        state_d = FLASH;
        count_d = '0;
        blink_d = 1'b1;
        ped_d   = 1'b0;
      end else if (state_q == FLASH) begin
        if (flash) begin
          blink_d = ~blink_q;
        end else begin
          state_d = R1;
          count_d = CNT_W'(ALLRED);
          blink_d = 1'b0;
        end
      end else if (count == '0) begin
        state_d = nxt(state_q);
        count_d = dur(nxt(state_q));
        ped_d   = 1'b0;
      end else begin
        // A pending request only exists in a green phase
        if (ped_pend && count > CNT_W'(PED_MIN)) count_d = CNT_W'(PED_MIN);
        else                                     count_d = count - CNT_W'(1);
        ped_d = 1'b0;
      end
    end

    // Latch requests only while green and not leaving the phase this cycle
    if (ped_req && (state_q == G0 || state_q == G1) && state_d == state_q)
      ped_d = 1'b1;

    case (state_d)
      G0:      begin tf0_d = 3'b010; tf1_d = 3'b100; end
      Y0:      begin tf0_d = 3'b001; tf1_d = 3'b100; end
      G1:      begin tf0_d = 3'b100; tf1_d = 3'b010; end
      Y1:      begin tf0_d = 3'b100; tf1_d = 3'b001; end
      FLASH:   begin tf0_d = {2'b00, blink_d}; tf1_d = {2'b00, blink_d}; end
      default: begin tf0_d = 3'b100; tf1_d = 3'b100; end
    endcase
  end

  // State, count and lamp registers
  always_ff @(posedge tclk) begin
    if (!rst) begin
      state_q  <= G0;
      count    <= CNT_W'(GREEN0);
      ped_pend <= 1'b0;
      blink_q  <= 1'b0;
      tf0      <= 3'b010;
      tf1      <= 3'b100;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      ped_pend <= ped_d;
      blink_q  <= blink_d;
      tf0      <= tf0_d;
      tf1      <= tf1_d;
    end
  end

endmodule

// File: tb/tb_trafficlights_controller_param.sv
// Scoreboard bench for trafficlights_controller_param: stimulus queues
// hand-computed expectations tagged with an edge number, a monitor checks them.
module tb_trafficlights_controller_param;

  logic       tclk;
  logic       rst;
  logic       ped_req;
  logic       flash;
  logic [2:0] tf0, tf1;
  logic [7:0] count;
  logic [2:0] phase;
  logic       ped_pend;

  trafficlights_controller_param #(
    .TICK_DIV(4), .CNT_W(8), .GREEN0(6), .GREEN1(4),
    .YELLOW(2), .ALLRED(1), .PED_MIN(2)
  ) dut (
    .tclk(tclk), .rst(rst), .ped_req(ped_req), .flash(flash),
    .tf0(tf0), .tf1(tf1), .count(count), .phase(phase), .ped_pend(ped_pend)
  );

  typedef struct {
    int         e;
    logic [2:0] ph;
    logic [7:0] cnt;
    logic [2:0] t0;
    logic [2:0] t1;
    logic       pend;
    logic       pchk;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t it;
  int   ec = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Free-run expectations after ticks 1..22 following reset
  int fr_ph[22]  = '{0,0,0,0,0,0,1,1,1,2,2,3,3,3,3,3,4,4,4,5,5,0};
  int fr_cnt[22] = '{5,4,3,2,1,0,2,1,0,1,0,4,3,2,1,0,2,1,0,1,0,6};

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  // Edge counter used to time-tag expectations
  always @(posedge tclk) ec <= ec + 1;

  // Monitor: compare every expectation due at this edge
  always @(negedge tclk) begin
    #1;
    while (q.size() > 0 && q[0].e <= ec) begin
      it = q.pop_front();
      n_cmp++;
      if (it.e != ec) begin
        n_mis++;
        $display("FAIL %s: check for edge %0d missed (now edge %0d)", it.name, it.e, ec);
      end else if (phase !== it.ph || count !== it.cnt || tf0 !== it.t0 ||
                   tf1 !== it.t1 || (it.pchk && ped_pend !== it.pend)) begin
        n_mis++;
        $display("FAIL %s @edge %0d: got ph=%0d cnt=%0d tf0=%b tf1=%b pend=%b, want ph=%0d cnt=%0d tf0=%b tf1=%b pend=%b%s",
                 it.name, ec, phase, count, tf0, tf1, ped_pend,
                 it.ph, it.cnt, it.t0, it.t1, it.pend, it.pchk ? "" : "(dc)");
      end
    end
  end

  task automatic chk(input string name, input int e, input int ph, input int cnt,
                     input bit blink, input bit pend, input bit pchk);
    exp_t x;
    x.e = e; x.ph = 3'(ph); x.cnt = 8'(cnt); x.pend = pend; x.pchk = pchk; x.name = name;
    case (ph)
      0: begin x.t0 = 3'b010; x.t1 = 3'b100; end
      1: begin x.t0 = 3'b001; x.t1 = 3'b100; end
      3: begin x.t0 = 3'b100; x.t1 = 3'b010; end
      4: begin x.t0 = 3'b100; x.t1 = 3'b001; end
      6: begin x.t0 = {2'b00, blink}; x.t1 = {2'b00, blink}; end
      default: begin x.t0 = 3'b100; x.t1 = 3'b100; end
    endcase
    q.push_back(x);
  endtask

  task automatic go_to(input int e);
    while (ec < e) @(negedge tclk);
  endtask

  // One reset edge; returns the edge number at release
  task automatic do_reset(output int r);
    @(negedge tclk);
    rst = 1'b0;
    @(negedge tclk);
    rst = 1'b1;
    r = ec;
  endtask

  initial begin
    int r, r2;
    rst = 1'b0; ped_req = 1'b0; flash = 1'b0;

    // Free-running normal cycle
    do_reset(r);
    chk("reset", r, 0, 6, 0, 0, 1);
    chk("first_tick_wait", r + 3, 0, 6, 0, 0, 1);
    for (int k = 1; k <= 22; k++) begin
      chk($sformatf("free_tick%0d", k), r + 4 * k, fr_ph[k-1], fr_cnt[k-1], 0, 0, 1);
      if (k == 1) chk("hold_between_ticks", r + 6, 0, 5, 0, 0, 1);
    end
    go_to(r + 89);

    // Pedestrian shortening at count 5
    do_reset(r);
    go_to(r + 5);
    ped_req = 1'b1;
    chk("ped_set", r + 6, 0, 5, 0, 1, 1);
    go_to(r + 6);
    ped_req = 1'b0;
    chk("ped_shorten", r + 8, 0, 2, 0, 0, 1);
    chk("ped_dec1", r + 12, 0, 1, 0, 0, 1);
    chk("ped_dec0", r + 16, 0, 0, 0, 0, 1);
    chk("ped_y0", r + 20, 1, 2, 0, 0, 1);
    go_to(r + 21);

    // Request at count 1 (no shortening) and during yellow (ignored)
    do_reset(r);
    go_to(r + 21);
    ped_req = 1'b1;
    chk("ped_low_set", r + 22, 0, 1, 0, 1, 1);
    go_to(r + 22);
    ped_req = 1'b0;
    chk("ped_low_noshort", r + 24, 0, 0, 0, 0, 0);
    chk("ped_low_y0", r + 28, 1, 2, 0, 0, 1);
    go_to(r + 29);
    ped_req = 1'b1;
    chk("ped_y0_ign_a", r + 30, 1, 2, 0, 0, 1);
    chk("ped_y0_ign_b", r + 32, 1, 1, 0, 0, 1);
    chk("ped_y0_ign_c", r + 34, 1, 1, 0, 0, 1);
    go_to(r + 34);
    ped_req = 1'b0;
    go_to(r + 35);

    // Flash mode entered mid G1
    do_reset(r);
    chk("g1_pre_flash", r + 52, 3, 3, 0, 0, 1);
    go_to(r + 53);
    flash = 1'b1;
    chk("flash_on", r + 56, 6, 0, 1, 0, 1);
    chk("flash_blink0", r + 60, 6, 0, 0, 0, 1);
    chk("flash_blink1", r + 64, 6, 0, 1, 0, 1);
    go_to(r + 65);
    flash = 1'b0;
    chk("flash_exit_r1", r + 68, 5, 1, 0, 0, 1);
    chk("flash_r1_dec", r + 72, 5, 0, 0, 0, 1);
    chk("flash_to_g0", r + 76, 0, 6, 0, 0, 1);
    go_to(r + 77);

    // Flash and pending request on the same tick
    do_reset(r);
    go_to(r + 1);
    ped_req = 1'b1;
    chk("pend_before_flash", r + 2, 0, 6, 0, 1, 1);
    go_to(r + 2);
    ped_req = 1'b0;
    flash = 1'b1;
    chk("flash_clr_pend", r + 4, 6, 0, 1, 0, 1);
    go_to(r + 5);
    flash = 1'b0;
    chk("flash_clr_exit", r + 8, 5, 1, 0, 0, 1);
    go_to(r + 9);

    // Reset in Y1
    do_reset(r);
    chk("reach_y1", r + 68, 4, 2, 0, 0, 1);
    go_to(r + 69);
    do_reset(r2);
    chk("midrst_state", r2, 0, 6, 0, 0, 1);
    chk("midrst_wait", r2 + 3, 0, 6, 0, 0, 1);
    chk("midrst_first_tick", r2 + 4, 0, 5, 0, 0, 1);
    go_to(r2 + 6);

    if (q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
